// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and width helpers
// Default data width, depth and pointer width used by the FIFO family.
// The fill counter needs one extra bit so it can represent FIFO_SIZE itself.
package fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_SIZE_BITS  = 3;
  localparam int FIFO_COUNT_BITS = FIFO_SIZE_BITS + 1;
  function automatic int count_width(input int size_bits);
    return size_bits + 1;
  endfunction
endpackage

// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: producer/consumer bus of the single-clock FIFO
// data/write_enable/read_enable flow into the FIFO; q, fill_count and the
// status flags flow out. master = the stage driving requests, slave = the FIFO.
interface fifo_sync_flags_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int SIZE_BITS  = FIFO_SIZE_BITS
);
  logic [DATA_WIDTH-1:0] data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [SIZE_BITS:0]    fill_count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output data, write_enable, read_enable,
    input  q, fifo_full, fifo_empty, almost_full, almost_empty, fill_count, overflow, underflow
  );
  modport slave (
    input  data, write_enable, read_enable,
    output q, fifo_full, fifo_empty, almost_full, almost_empty, fill_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: simple dual-port register array, synchronous write, combinational read
// Ports: clock, write_enable, write_address, write_data, read_address, read_data.
// Contents are never reset.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_BITS  = 3
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [SIZE_BITS-1:0]  write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [SIZE_BITS-1:0]  read_address,
  output logic [DATA_WIDTH-1:0] read_data
);
  logic [DATA_WIDTH-1:0] mem [2**SIZE_BITS];
  always_ff @(posedge clock)
    if (write_enable) mem[write_address] <= write_data;
  assign read_data = mem[read_address];
endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with fill count, almost flags and sticky error flags
// Ports: clock, reset (sync, active-high), bus (fifo_sync_flags_if.slave:
// data/write_enable/read_enable in; q, fill_count, fifo_full, fifo_empty,
// almost_full, almost_empty, overflow, underflow out).
// Define FIFO_FWFT_EN for first-word fall-through: q shows the head word
// combinationally while not empty (0 when empty). Otherwise q is registered
// and valid one cycle after an accepted read.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = FIFO_DATA_WIDTH,
  parameter int FIFO_SIZE          = FIFO_DEPTH,
  parameter int SIZE_BITS          = FIFO_SIZE_BITS,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input logic              clock,
  input logic              reset,
  fifo_sync_flags_if.slave bus
);
  localparam int CW = count_width(SIZE_BITS);
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_SIZE);
  localparam logic [CW-1:0] AF_C   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(ALMOST_EMPTY_LEVEL);
  logic [SIZE_BITS-1:0]  write_pointer, read_pointer;
  logic [CW-1:0]         count, count_next;
  logic                  full, empty, afull, aempty, ovf, unf;
  logic                  write_ok, read_ok;
  logic [DATA_WIDTH-1:0] head;
  assign write_ok   = bus.write_enable & ~full;
  assign read_ok    = bus.read_enable & ~empty;
  assign count_next = count + CW'(write_ok) - CW'(read_ok);
  fifo_mem_dp #(.DATA_WIDTH(DATA_WIDTH), .SIZE_BITS(SIZE_BITS)) u_mem (
    .clock        (clock),
    .write_enable (write_ok),
    .write_address(write_pointer),
    .write_data   (bus.data),
    .read_address (read_pointer),
    .read_data    (head)
  );
  // Flags are registered from count_next so they line up with fill_count.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      afull         <= 1'b0;
      aempty        <= 1'b1;
      ovf           <= 1'b0;
      unf           <= 1'b0;
    end else begin
      write_pointer <= write_pointer + SIZE_BITS'(write_ok);
      read_pointer  <= read_pointer + SIZE_BITS'(read_ok);
      count         <= count_next;
      full          <= count_next == FULL_C;
      empty         <= count_next == '0;
      afull         <= count_next >= AF_C;
      aempty        <= count_next <= AE_C;
      ovf           <= ovf | (bus.write_enable & full);
      unf           <= unf | (bus.read_enable & empty);
    end
  end
`ifdef FIFO_FWFT_EN
  assign bus.q = empty ? '0 : head;
`else
  logic [DATA_WIDTH-1:0] q_reg;
  always_ff @(posedge clock)
    if (reset) q_reg <= '0;
    else if (read_ok) q_reg <= head;
  assign bus.q = q_reg;
`endif
  assign bus.fill_count   = count;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = afull;
  assign bus.almost_empty = aempty;
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: directed + randomized check of fifo_sync_flags against a queue model
module tb_fifo_sync_flags;
  localparam int DW = 8;
  localparam int N  = 8;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  fifo_sync_flags_if #(.DATA_WIDTH(DW), .SIZE_BITS(3)) bus();
  fifo_sync_flags #(
    .DATA_WIDTH(DW), .FIFO_SIZE(N), .SIZE_BITS(3),
    .ALMOST_FULL_LEVEL(6), .ALMOST_EMPTY_LEVEL(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  int passed = 0;
  int total  = 0;
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] mq;
  logic mov, mun;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [DW-1:0] exp_q();
`ifdef FIFO_FWFT_EN
    return mdl.size() != 0 ? mdl[0] : '0;
`else
    return mq;
`endif
  endfunction
  task automatic compare();
    int s;
    s = mdl.size();
    check("fill_count", 32'(bus.fill_count), s);
    check("fifo_full", 32'(bus.fifo_full), 32'(s == N));
    check("fifo_empty", 32'(bus.fifo_empty), 32'(s == 0));
    check("almost_full", 32'(bus.almost_full), 32'(s >= 6));
    check("almost_empty", 32'(bus.almost_empty), 32'(s <= 2));
    check("overflow", 32'(bus.overflow), 32'(mov));
    check("underflow", 32'(bus.underflow), 32'(mun));
    check("q", 32'(bus.q), 32'(exp_q()));
  endtask
  // One clock: drive, let the DUT and the model both take the edge, then compare.
  task automatic step(input logic rst, input logic we, input logic re, input logic [DW-1:0] d);
    bit full, empty;
    reset = rst;
    bus.write_enable = we;
    bus.read_enable = re;
    bus.data = d;
    @(posedge clock);
    if (rst) begin
      mdl.delete();
      mq = '0;
      mov = 1'b0;
      mun = 1'b0;
    end else begin
      full = mdl.size() == N;
      empty = mdl.size() == 0;
      if (we && full) mov = 1'b1;
      if (re && empty) mun = 1'b1;
      if (re && !empty) mq = mdl.pop_front();
      if (we && !full) mdl.push_back(d);
    end
    @(negedge clock);
    compare();
  endtask
  initial begin
    int we_p, re_p;
    step(1, 0, 0, 8'h00);
    check("rst_count", 32'(bus.fill_count), 0);
    check("rst_empty", 32'(bus.fifo_empty), 1);
    check("rst_q", 32'(bus.q), 0);
    // fill 0x01..0x08
    for (int k = 1; k <= N; k++) begin
      step(0, 1, 0, 8'(k));
      check("t1_count", 32'(bus.fill_count), k);
      check("t1_af", 32'(bus.almost_full), 32'(k >= 6));
      check("t1_empty", 32'(bus.fifo_empty), 0);
    end
    check("t1_full", 32'(bus.fifo_full), 1);
    // drain, q follows each read by one cycle in registered mode
    for (int k = 1; k <= N; k++) begin
      step(0, 0, 1, 8'h00);
      check("t2_count", 32'(bus.fill_count), N - k);
`ifndef FIFO_FWFT_EN
      check("t2_q", 32'(bus.q), k);
`endif
      check("t2_ae", 32'(bus.almost_empty), 32'((N - k) <= 2));
    end
    check("t2_empty", 32'(bus.fifo_empty), 1);
    // full + simultaneous read/write
    for (int k = 0; k < N; k++) step(0, 1, 0, 8'(8'h30 + k));
    step(0, 1, 1, 8'hAA);
    check("t3_count", 32'(bus.fill_count), 7);
    check("t3_ovf", 32'(bus.overflow), 1);
    step(0, 0, 0, 8'h00);
    check("t3_ovf_sticky", 32'(bus.overflow), 1);
    for (int k = 0; k < 7; k++) step(0, 0, 1, 8'h00);
`ifndef FIFO_FWFT_EN
    check("t3_last_q", 32'(bus.q), 32'h37);
`endif
    // empty + simultaneous read/write
    step(0, 1, 1, 8'h55);
    check("t4_count", 32'(bus.fill_count), 1);
    check("t4_unf", 32'(bus.underflow), 1);
`ifndef FIFO_FWFT_EN
    check("t4_q_held", 32'(bus.q), 32'h37);
`endif
    step(0, 0, 1, 8'h00);
    check("t4_q", 32'(bus.q), 32'h55);
    // reset mid-burst discards data
    step(1, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'(8'hC0 + k));
    step(1, 1, 0, 8'hEE);
    check("t5_count", 32'(bus.fill_count), 0);
    check("t5_ovf", 32'(bus.overflow), 0);
    check("t5_q", 32'(bus.q), 0);
    step(0, 1, 0, 8'h9A);
    step(0, 0, 1, 8'h00);
    check("t5_new", 32'(bus.q), 32'h9A);
`ifdef FIFO_FWFT_EN
    step(0, 1, 0, 8'h11);
    check("t6_head", 32'(bus.q), 32'h11);
    step(0, 1, 0, 8'h22);
    step(0, 0, 1, 8'h00);
    check("t6_pop", 32'(bus.q), 32'h22);
`endif
    // random traffic alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      we_p = ((i / 48) % 2) ? 75 : 25;
      re_p = 100 - we_p;
      step($urandom_range(0, 599) == 0,
           $urandom_range(0, 99) < we_p,
           $urandom_range(0, 99) < re_p,
           8'($urandom));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Single-clock, parametrised successor to the team's dual-clock FIFO. It adds a fill counter, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and defined simultaneous read/write behaviour. It sits between producer and consumer stages in the same clock domain, for example as a packet staging buffer or a receive-data queue.

Parameters:
DATA_WIDTH, 32, width of each stored word.
FIFO_SIZE, 8, depth in words; must equal 2**SIZE_BITS.
SIZE_BITS, 3, pointer width.
ALMOST_FULL_LEVEL, 6, almost_full asserts when fill_count >= this value (1..FIFO_SIZE).
ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when fill_count <= this value (0..FIFO_SIZE-1).

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
data  input  DATA_WIDTH  write data.
write_enable  input  1  write request.
read_enable  input  1  read request.
q  output  DATA_WIDTH  read data.
fifo_full  output  1  fill_count == FIFO_SIZE.
fifo_empty  output  1  fill_count == 0.
almost_full  output  1  fill_count >= ALMOST_FULL_LEVEL.
almost_empty  output  1  fill_count <= ALMOST_EMPTY_LEVEL.
fill_count  output  SIZE_BITS+1  number of stored words, 0..FIFO_SIZE.
overflow  output  1  sticky: write attempted while full.
underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (sampled on the clock edge, active-high):
  - Pointers and fill_count are cleared to 0.
  - q is cleared to 0.
  - fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
- Reset mid-operation discards all stored data. The first write after reset lands at address 0.
- Write acceptance: write_ok = write_enable & ~fifo_full. On write_ok, mem[write_pointer] <= data and write_pointer increments.
- Read acceptance: read_ok = read_enable & ~fifo_empty. On read_ok, q <= mem[read_pointer] and read_pointer increments.
  - q is valid one cycle after read_ok.
  - q holds its last value when no read is accepted.
- Pointer wrap: pointers are SIZE_BITS wide and wrap naturally from FIFO_SIZE-1 to 0. Full and empty are resolved by fill_count, not by pointer comparison.
- fill_count update: +1 on write_ok only, -1 on read_ok only, unchanged on both or neither. It never exceeds FIFO_SIZE or drops below 0.
- All flags are registered and computed from next-state fill_count, so they are valid in the same cycle fill_count updates.
- Simultaneous read and write:
  - Full: the read is accepted, the write is rejected (fifo_full gates it), overflow sets, and the count drops to FIFO_SIZE-1.
  - Empty: the write is accepted, the read is rejected, underflow sets, and the count rises to 1. No read-through of same-cycle write data.
  - Otherwise: both are accepted and the count is unchanged.
- overflow sets on write_enable & fifo_full. underflow sets on read_enable & fifo_empty. Both stay set until reset.
- Rejected operations never change pointers, memory, or q.

Optional Feature:
FIFO_FWFT_EN (first-word fall-through):
- Defined: q continuously presents mem[read_pointer] whenever fifo_empty=0, so the head word is visible with zero latency. read_ok pops the head and q shows the next word in the same cycle as the pointer update. q is don't-care while empty (driven 0).
- Undefined: standard mode with registered q and 1-cycle read latency, as described above.
- Flags, counters and error behaviour are identical in both modes.

Decomposition:
- Shared package fifo_pkg: default DATA_WIDTH/FIFO_SIZE/SIZE_BITS constants and a count-width constant (SIZE_BITS+1), reused by the existing dual-clock FIFO and future FIFOs.
- One natural sub-module: fifo_mem_dp, a simple dual-port register array.
  - Ports: clock, write_enable, write_address, write_data, read_address, read_data (combinational read).
  - The top level owns pointers, count, flags and the q register.

Test Plan:
1. Reset, then 8 writes of 0x01..0x08 (DATA_WIDTH=8) -> fill_count steps 1..8; almost_full rises on the write that makes fill_count 6; fifo_full=1 after the 8th write; fifo_empty=0 after the 1st.
2. From full, 8 reads -> q = 0x01..0x08, each one cycle after its read; almost_empty=1 at fill_count 2; fifo_empty=1 after the 8th read; pointers wrap to 0.
3. Full FIFO, assert read_enable and write_enable together with data=0xAA -> read accepted, write rejected, fill_count=7, overflow=1 and stays 1.
4. Empty FIFO, read_enable with write_enable and data=0x55 -> fill_count=1, underflow=1, q unchanged; next-cycle read returns 0x55.
5. Write 5 words, assert reset for 1 cycle mid-burst -> all outputs at reset values next cycle; the next write then read returns the new data, not stale data.
6. With FIFO_FWFT_EN: write 0x11 -> q=0x11 without a read; write 0x22, pop -> q=0x22 in the pop cycle.
